rr_arbiter_8_enc: RTL and testbench
===================================

// Module: rr_arbiter_8_enc
// PURPOSE
//  Round-robin arbiter sharing one resource among 8 requesters.
//  Grant is issued both as a one-hot vector and as a 3-bit encoded index, with a bounded hold time.
//  Sits in front of the 8-to-3 encoder datapath: gnt is always one-hot or zero, so it is a legal encoder input.
//  gnt_idx equals what that encoder would produce from gnt.
// PARAMETERS
//  MAX_HOLD  16  max consecutive cycles one requester may hold the grant (>=1)
// PORTS
//  clk        in   1  single clock, rising edge
//  rst        in   1  reset, synchronous, active-high
//  req        in   8  request vector, bit i = requester i; level, held while resource wanted
//  gnt        out  8  one-hot grant, all-zero when idle
//  gnt_idx    out  3  binary index of granted requester; 0 when idle
//  gnt_valid  out  1  high whenever gnt != 0
//  preempt    out  1  one-cycle pulse: grant was forcibly rotated by hold timeout
// BEHAVIOUR
//  - All outputs registered. On rst: state=IDLE, gnt=0, gnt_idx=0, gnt_valid=0, preempt=0, ptr=0, hold_cnt=0.
//  - rst dominates everything, including mid-grant: next cycle all outputs are 0 and ptr=0.
//  - ptr (3b) is the search start. Pick = first set bit of req scanning ptr, ptr+1, ... mod 8 (wraps 7->0).
//  - IDLE: if req!=0, load grant=pick; go GRANT; hold_cnt=0. Latency: req high at edge k -> gnt at k+1.
//  - GRANT (grantee g), evaluated each edge, first match wins:
//    a) req[g]==0 (release): re-pick from ptr=g+1 mod 8.
//       If another req is set -> grant it next cycle (no bubble), hold_cnt=0.
//       Otherwise -> IDLE, gnt=0.
//       ptr := g+1 mod 8 in both cases.
//    b) req[g]==1 && hold_cnt==MAX_HOLD-1 (timeout): re-pick from g+1 with req[g] masked.
//       If another req is set -> grant it, preempt=1 for that one cycle.
//       Otherwise -> re-grant g, hold_cnt=0, preempt=0.
//       ptr := g+1 mod 8.
//    c) else: hold grant, hold_cnt++.
//  - A grantee therefore sees gnt_valid for at most MAX_HOLD consecutive cycles while others wait.
//  - New requests arriving during GRANT never change the current grant.
//  - req bits that drop before being granted are simply not picked. No request queuing.
//  - hold_cnt width $clog2(MAX_HOLD); no wrap possible because of the timeout compare.
//  - Simultaneous release of g and new request from g in the same cycle: treated as release (req[g] sampled 0).
//  - MAX_HOLD==1: every grant lasts one cycle; rotates every cycle if others request.
// STRUCTURE
//  - Shared package: N_REQ=8, IDX_W=3, state enum {IDLE, GRANT}.
//  - Sub-module rr_pick_8 (combinational): inputs req[7:0], start[2:0], mask_en, mask_idx[2:0].
//    Outputs pick_valid, pick_idx[2:0], pick_onehot[7:0].
//    Implemented as rotate -> fixed-priority encode -> un-rotate.
//  - Top: state/ptr/hold_cnt registers plus output registers.
// TESTING
//  1. Reset: assert rst 2 cycles with req=8'hFF -> gnt=0, gnt_idx=0, gnt_valid=0, preempt=0 throughout.
//  2. Single: req=8'h10 at edge k -> gnt=8'h10, gnt_idx=4 at k+1.
//     Drop req -> gnt=0 next cycle; ptr=5.
//  3. Fairness/wrap: after reset, req=8'h81 held, each grantee releases after 3 cycles.
//     Expected grant sequence: 0, 7, 0, 7...
//     Back-to-back handover with no idle cycle.
//  4. Timeout: MAX_HOLD=4, req=8'h06 held constant.
//     gnt_idx=1 for 4 cycles, then 2 for 4 cycles with preempt pulse, alternating.
//     Lone req=8'h02 held: gnt_idx=1 continuously, preempt never asserted.
//  5. Reset mid-grant: grant to 5 active, rst for 1 cycle -> outputs 0.
//     With req=8'h21 after reset: grant to 0 first (ptr reset).
//  6. Random req for 10k cycles, checked by scoreboard:
//     - gnt is one-hot or zero
//     - gnt_idx matches encode(gnt)
//     - no requester waits more than 7*MAX_HOLD+8 cycles
//     - gnt only ever goes to a requester whose req was high at the previous edge

Source files
------------

// File: rtl/rr_arbiter_8_enc_pkg.sv
// Shared constants and state type for the 8-way round-robin arbiter
// and its rotating priority picker.
package rr_arbiter_8_enc_pkg;
    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;
endpackage

// File: rtl/rr_arbiter_8_enc_pick.sv
// Combinational rotating-priority picker: finds the first set request at or
// after 'start' (wrapping), optionally ignoring one masked requester.
module rr_pick_8
    import rr_arbiter_8_enc_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] start,
    input  logic             mask_en,
    input  logic [IDX_W-1:0] mask_idx,
    output logic             pick_valid,
    output logic [IDX_W-1:0] pick_idx,
    output logic [N_REQ-1:0] pick_onehot
);
    logic [N_REQ-1:0] masked;
    logic [N_REQ-1:0] rot;
    logic [IDX_W-1:0] offset;

    assign masked = req & ~(mask_en ? (N_REQ'(1) << mask_idx) : '0);

    // Rotate so that position 0 of rot corresponds to requester 'start'.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
            logic [IDX_W-1:0] src;
            assign src     = IDX_W'(gi) + start;
            assign rot[gi] = masked[src];
        end
    endgenerate

    always_comb begin
        pick_valid = 1'b0;
        offset     = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                pick_valid = 1'b1;
                offset     = IDX_W'(i);
            end
        end
    end

    // Un-rotate; modulo-8 wrap falls out of the 3-bit add.
    assign pick_idx    = offset + start;
    assign pick_onehot = pick_valid ? (N_REQ'(1) << pick_idx) : '0;
endmodule

// File: rtl/rr_arbiter_8_enc.sv
// Round-robin arbiter for 8 requesters with bounded hold time; grant is
// registered both one-hot and as a binary index.
module rr_arbiter_8_enc
    import rr_arbiter_8_enc_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             preempt
);
    // Keep at least one bit so MAX_HOLD==1 still has a legal counter.
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    arb_state_t       state_reg, state_next;
    logic [IDX_W-1:0] ptr_reg, ptr_next;
    logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
    logic [N_REQ-1:0] gnt_reg, gnt_next;
    logic [IDX_W-1:0] gnt_idx_reg, gnt_idx_next;
    logic             gnt_valid_reg, gnt_valid_next;
    logic             preempt_reg, preempt_next;

    logic [IDX_W-1:0] pick_start;
    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic [N_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0] after_g;

    // While granting, search resumes just past the grantee; masking it only
    // matters on timeout, since on release its request is already low.
    assign after_g    = gnt_idx_reg + 3'd1;
    assign pick_start = (state_reg == GRANT) ? after_g : ptr_reg;

    rr_pick_8 u_pick (
        .req         (req),
        .start       (pick_start),
        .mask_en     (state_reg == GRANT),
        .mask_idx    (gnt_idx_reg),
        .pick_valid  (pick_valid),
        .pick_idx    (pick_idx),
        .pick_onehot (pick_onehot)
    );

    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        hold_cnt_next  = hold_cnt_reg;
        gnt_next       = gnt_reg;
        gnt_idx_next   = gnt_idx_reg;
        gnt_valid_next = gnt_valid_reg;
        preempt_next   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    state_next     = GRANT;
                    gnt_next       = pick_onehot;
                    gnt_idx_next   = pick_idx;
                    gnt_valid_next = 1'b1;
                    hold_cnt_next  = '0;
                end
            end
            GRANT: begin
                if (!req[gnt_idx_reg]) begin
                    ptr_next      = after_g;
                    hold_cnt_next = '0;
                    if (pick_valid) begin
                        gnt_next     = pick_onehot;
                        gnt_idx_next = pick_idx;
                    end else begin
                        state_next     = IDLE;
                        gnt_next       = '0;
                        gnt_idx_next   = '0;
                        gnt_valid_next = 1'b0;
                    end
                end else if (hold_cnt_reg == HOLD_W'(MAX_HOLD - 1)) begin
                    // Timeout: hand over if anyone else waits, else re-grant.
                    ptr_next      = after_g;
                    hold_cnt_next = '0;
                    if (pick_valid) begin
                        gnt_next     = pick_onehot;
                        gnt_idx_next = pick_idx;
                        preempt_next = 1'b1;
                    end
                end else begin
                    hold_cnt_next = hold_cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            hold_cnt_reg  <= '0;
            gnt_reg       <= '0;
            gnt_idx_reg   <= '0;
            gnt_valid_reg <= 1'b0;
            preempt_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            hold_cnt_reg  <= hold_cnt_next;
            gnt_reg       <= gnt_next;
            gnt_idx_reg   <= gnt_idx_next;
            gnt_valid_reg <= gnt_valid_next;
            preempt_reg   <= preempt_next;
        end
    end

    assign gnt       = gnt_reg;
    assign gnt_idx   = gnt_idx_reg;
    assign gnt_valid = gnt_valid_reg;
    assign preempt   = preempt_reg;
endmodule

// File: tb/tb_rr_arbiter_8_enc.sv
// Bench for rr_arbiter_8_enc: directed vector table, reset-mid-grant sequence,
// then randomized traffic against a behavioural model plus invariant checks.
module tb_rr_arbiter_8_enc;
    localparam int MAX_HOLD = 4;
    localparam int WAIT_BOUND = 7 * MAX_HOLD + 8;
    localparam int N_RAND = 10000;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       preempt;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state: current grantee (-1 idle), search pointer,
    // cycles already held beyond the first, and last preempt pulse.
    int m_g    = -1;
    int m_ptr  = 0;
    int m_hold = 0;
    bit m_pre  = 1'b0;

    int waitc [8];

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic [2:0] idx;
        logic       valid;
        logic       pre;
        string      name;
    } vec_t;
    vec_t vecs[$];

    rr_arbiter_8_enc #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    always #5 clk = ~clk;

    function automatic int m_pick(input logic [7:0] r, input int start, input int excl);
        for (int k = 0; k < 8; k++) begin
            int j;
            j = (start + k) % 8;
            if (j != excl && r[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_step(input logic r_rst, input logic [7:0] r);
        int p;
        m_pre = 1'b0;
        if (r_rst) begin
            m_g = -1; m_ptr = 0; m_hold = 0;
        end else if (m_g < 0) begin
            p = m_pick(r, m_ptr, -1);
            if (p >= 0) begin m_g = p; m_hold = 0; end
        end else if (!r[m_g]) begin
            p = m_pick(r, (m_g + 1) % 8, -1);
            m_ptr = (m_g + 1) % 8;
            m_g = p;
            m_hold = 0;
        end else if (m_hold == MAX_HOLD - 1) begin
            p = m_pick(r, (m_g + 1) % 8, m_g);
            m_ptr = (m_g + 1) % 8;
            m_hold = 0;
            if (p >= 0) begin m_g = p; m_pre = 1'b1; end
        end else begin
            m_hold++;
        end
    endtask

    // Drive at the falling edge, let one rising edge pass, sample 1 time unit later.
    task automatic step(input logic r_rst, input logic [7:0] r);
        @(negedge clk);
        rst = r_rst;
        req = r;
        @(posedge clk);
        #1;
        model_step(r_rst, r);
    endtask

    task automatic check_out(input string name, input logic [2:0] idx,
                             input logic valid, input logic pre);
        logic [12:0] act, exp;
        act = {gnt, gnt_idx, gnt_valid, preempt};
        exp = {(valid ? (8'h01 << idx) : 8'h00), (valid ? idx : 3'd0), valid, pre};
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: gnt=%h idx=%0d valid=%b preempt=%b, required gnt=%h idx=%0d valid=%b preempt=%b",
                     name, gnt, gnt_idx, gnt_valid, preempt,
                     exp[12:5], exp[4:2], exp[1], exp[0]);
        end
    endtask

    task automatic add_vec(input logic r_rst, input logic [7:0] r, input logic [2:0] idx,
                           input logic valid, input logic pre, input string name);
        vec_t v;
        v.rst = r_rst; v.req = r; v.idx = idx; v.valid = valid; v.pre = pre; v.name = name;
        vecs.push_back(v);
    endtask

    initial begin
        // Reset held with all requests pending.
        add_vec(1, 8'hFF, 0, 0, 0, "reset_0");
        add_vec(1, 8'hFF, 0, 0, 0, "reset_1");
        // Single requester, release, then pointer shows up as search start 5.
        add_vec(0, 8'h10, 4, 1, 0, "single_grant");
        add_vec(0, 8'h00, 0, 0, 0, "single_release");
        add_vec(0, 8'hFF, 5, 1, 0, "ptr_after_release");
        add_vec(0, 8'h00, 0, 0, 0, "idle_again");
        // Fairness with wrap: 0 and 7 alternate, each releasing after 3 cycles.
        add_vec(1, 8'h00, 0, 0, 0, "wrap_reset");
        add_vec(0, 8'h81, 0, 1, 0, "wrap_g0_c1");
        add_vec(0, 8'h81, 0, 1, 0, "wrap_g0_c2");
        add_vec(0, 8'h81, 0, 1, 0, "wrap_g0_c3");
        add_vec(0, 8'h80, 7, 1, 0, "wrap_g7_c1");
        add_vec(0, 8'h81, 7, 1, 0, "wrap_g7_c2");
        add_vec(0, 8'h81, 7, 1, 0, "wrap_g7_c3");
        add_vec(0, 8'h01, 0, 1, 0, "wrap_g0b_c1");
        add_vec(0, 8'h81, 0, 1, 0, "wrap_g0b_c2");
        add_vec(0, 8'h81, 0, 1, 0, "wrap_g0b_c3");
        add_vec(0, 8'h80, 7, 1, 0, "wrap_g7b_c1");
        // Timeout rotation between 1 and 2, then a lone holder never preempted.
        add_vec(1, 8'h00, 0, 0, 0, "to_reset");
        for (int c = 0; c < 4; c++) add_vec(0, 8'h06, 1, 1, 0, "to_g1");
        add_vec(0, 8'h06, 2, 1, 1, "to_preempt_2");
        for (int c = 0; c < 3; c++) add_vec(0, 8'h06, 2, 1, 0, "to_g2");
        add_vec(0, 8'h06, 1, 1, 1, "to_preempt_1");
        for (int c = 0; c < 6; c++) add_vec(0, 8'h02, 1, 1, 0, "lone_hold");

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].req);
            check_out(vecs[i].name, vecs[i].idx, vecs[i].valid, vecs[i].pre);
            $display("vec %0d %s: req=%h gnt=%h idx=%0d valid=%b preempt=%b",
                     i, vecs[i].name, vecs[i].req, gnt, gnt_idx, gnt_valid, preempt);
        end

        // Reset in the middle of a grant clears the pointer as well.
        step(1, 8'h00);
        step(0, 8'h20); check_out("mid_grant_5", 5, 1, 0);
        step(0, 8'h20); check_out("mid_hold_5", 5, 1, 0);
        step(1, 8'h21); check_out("mid_reset", 0, 0, 0);
        step(0, 8'h21); check_out("post_reset_ptr0", 0, 1, 0);

        // Randomized traffic.
        begin
            logic [7:0] cur;
            logic [7:0] exp_gnt;
            logic       r_rst;
            int         max_wait;
            int         enc;
            cur = 8'h00;
            step(1, 8'h00);
            foreach (waitc[i]) waitc[i] = 0;
            for (int t = 0; t < N_RAND; t++) begin
                for (int i = 0; i < 8; i++) begin
                    if (gnt_valid && gnt_idx == 3'(i)) begin
                        if ($urandom_range(0, 5) == 0) cur[i] = 1'b0;
                    end else if (!cur[i]) begin
                        if ($urandom_range(0, 3) == 0) cur[i] = 1'b1;
                    end else if ($urandom_range(0, 19) == 0) begin
                        cur[i] = 1'b0;
                    end
                end
                r_rst = ($urandom_range(0, 499) == 0);
                step(r_rst, cur);

                exp_gnt = (m_g >= 0) ? (8'h01 << m_g) : 8'h00;
                n_checks++;
                if ({gnt, gnt_valid, preempt} !== {exp_gnt, (m_g >= 0), m_pre}) begin
                    n_fail++;
                    $display("FAIL rand_model t=%0d: gnt=%h valid=%b preempt=%b, required gnt=%h valid=%b preempt=%b",
                             t, gnt, gnt_valid, preempt, exp_gnt, (m_g >= 0), m_pre);
                end

                n_checks++;
                if ($countones(gnt) > 1) begin
                    n_fail++;
                    $display("FAIL rand_onehot t=%0d: gnt=%h, required one-hot or zero", t, gnt);
                end

                enc = 0;
                for (int i = 0; i < 8; i++) if (gnt[i]) enc = i;
                n_checks++;
                if (gnt_idx !== 3'(enc)) begin
                    n_fail++;
                    $display("FAIL rand_encode t=%0d: gnt_idx=%0d, required %0d for gnt=%h", t, gnt_idx, enc, gnt);
                end

                n_checks++;
                if (gnt_valid && !cur[gnt_idx]) begin
                    n_fail++;
                    $display("FAIL rand_req_high t=%0d: granted %0d, required req bit high (req=%h)", t, gnt_idx, cur);
                end

                max_wait = 0;
                for (int i = 0; i < 8; i++) begin
                    if (!r_rst && cur[i] && !gnt[i]) waitc[i]++;
                    else waitc[i] = 0;
                    if (waitc[i] > max_wait) max_wait = waitc[i];
                end
                n_checks++;
                if (max_wait > WAIT_BOUND) begin
                    n_fail++;
                    $display("FAIL rand_wait t=%0d: wait=%0d, required <= %0d", t, max_wait, WAIT_BOUND);
                end

                if (t % 1000 == 0)
                    $display("rand %0d: rst=%b req=%h gnt=%h idx=%0d preempt=%b",
                             t, r_rst, cur, gnt, gnt_idx, preempt);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
